clkgen_tick_mc: RTL and testbench

Multi-channel programmable tick generator. One shared prescaler divides iCLK into a base tick, 10 ms by default at 10 MHz. NCH independent channel timers count base ticks against per-channel periods, in periodic or one-shot mode, and raise tick pulses and sticky done flags. The block sits between the system clock and the peripheral timers or watchdogs that need several slow time bases.

---
 rtl/clkgen_tick_mc.sv | 179 +++++++++++++++++
 tb/tb_clkgen_tick_mc.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_tick_mc.sv
// clkgen_tick_mc
// Multi-channel programmable tick generator. A shared prescaler divides iCLK
// into a one-cycle base tick every CLK_DIV cycles. NCH channel timers count
// base ticks against per-channel periods (periodic or one-shot) and emit
// one-cycle expiry pulses plus sticky done flags.
//
// Parameters:
//   CLK_DIV  iCLK cycles per base tick (>= 2)
//   PSW      prescaler counter width, 2**PSW >= CLK_DIV
//   NCH      number of channels (1..16)
//   PW       channel period / counter width
//
// Ports:
//   iCLK        clock, rising edge
//   iRESET      synchronous active-high reset
//   iCK_RUN     prescaler count enable
//   iCK_RST     soft clear of prescaler and all channels (done flags kept)
//   iCH_START   per-channel start/restart pulse
//   iCH_STOP    per-channel stop pulse (beats START and expiry)
//   iCH_MODE    per-channel mode, 0 periodic / 1 one-shot, sampled at START
//   iCH_PERIOD  channel i period in base ticks at [i*PW +: PW]
//   iCH_CLR     per-channel clear of the sticky done flag
//   oBASE_TICK  one-cycle base tick pulse
//   oCH_TICK    one-cycle channel expiry pulse
//   oCH_DONE    sticky expiry flag
//   oCH_BUSY    channel is running
module clkgen_tick_mc #(
  parameter int CLK_DIV = 100000,
  parameter int PSW     = 17,
  parameter int NCH     = 4,
  parameter int PW      = 8
) (
  input  logic            iCLK,
  input  logic            iRESET,
  input  logic            iCK_RUN,
  input  logic            iCK_RST,
  input  logic [NCH-1:0]  iCH_START,
  input  logic [NCH-1:0]  iCH_STOP,
  input  logic [NCH-1:0]  iCH_MODE,
  input  logic [NCH*PW-1:0] iCH_PERIOD,
  input  logic [NCH-1:0]  iCH_CLR,
  output logic            oBASE_TICK,
  output logic [NCH-1:0]  oCH_TICK,
  output logic [NCH-1:0]  oCH_DONE,
  output logic [NCH-1:0]  oCH_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam logic [PSW-1:0] PCNT_MAX = PSW'(CLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------
  logic [PSW-1:0] pcnt_q, pcnt_d;
  logic           base_tick_q, base_tick_d;

  always_comb begin
    pcnt_d      = pcnt_q;
    base_tick_d = 1'b0;
    if (iCK_RST) begin
      // Soft clear also drops a base tick that was about to be issued.
      pcnt_d = '0;
    end else if (iCK_RUN) begin
      if (pcnt_q == PCNT_MAX) begin
        pcnt_d      = '0;
        base_tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PSW'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      pcnt_q      <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  assign oBASE_TICK = base_tick_q;

  // ---------------------------------------------------------------------------
  // Channel timers
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ch_state_e       state_q, state_d;
    logic [PW-1:0]   ccnt_q, ccnt_d;
    logic [PW-1:0]   shadow_q, shadow_d;
    logic            mode_q, mode_d;
    logic            tick_q, tick_d;
    logic            done_q, done_d;
    logic [PW-1:0]   period_in;
    logic [PW-1:0]   period_eff;

    assign period_in  = iCH_PERIOD[gi*PW +: PW];
    // A zero period is treated as one base tick so the channel never stalls.
    assign period_eff = (period_in == '0) ? PW'(1) : period_in;

    always_comb begin
      state_d  = state_q;
      ccnt_d   = ccnt_q;
      shadow_d = shadow_q;
      mode_d   = mode_q;
      tick_d   = 1'b0;

      if (iCK_RST) begin
        state_d  = ST_IDLE;
        ccnt_d   = '0;
        shadow_d = '0;
        mode_d   = 1'b0;
      end else if (iCH_STOP[gi]) begin
        state_d = ST_IDLE;
        ccnt_d  = '0;
      end else if (iCH_START[gi]) begin
        // Restart wins over counting, so an expiry in this cycle is discarded.
        state_d  = ST_RUN;
        ccnt_d   = '0;
        shadow_d = period_eff;
        mode_d   = iCH_MODE[gi];
      end else begin
        case (state_q)
          ST_RUN: begin
            if (base_tick_q) begin
              // shadow_q is at least 1 whenever the channel is running.
              if (ccnt_q == shadow_q - PW'(1)) begin
                tick_d = 1'b1;
                ccnt_d = '0;
                if (mode_q) begin
                  state_d = ST_DONE;
                end else begin
                  shadow_d = period_eff;
                end
              end else begin
                ccnt_d = ccnt_q + PW'(1);
              end
            end
          end
          default: begin
            ccnt_d = '0;
          end
        endcase
      end

      // Setting takes precedence over a clear in the same cycle.
      done_d = tick_d | (done_q & ~iCH_CLR[gi]);
    end

    always_ff @(posedge iCLK) begin
      if (iRESET) begin
        state_q  <= ST_IDLE;
        ccnt_q   <= '0;
        shadow_q <= '0;
        mode_q   <= 1'b0;
        tick_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        ccnt_q   <= ccnt_d;
        shadow_q <= shadow_d;
        mode_q   <= mode_d;
        tick_q   <= tick_d;
        done_q   <= done_d;
      end
    end

    assign oCH_TICK[gi] = tick_q;
    assign oCH_DONE[gi] = done_q;
    assign oCH_BUSY[gi] = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_clkgen_tick_mc.sv
// Self-checking bench for clkgen_tick_mc with CLK_DIV=4, NCH=4, PW=8.
// A behavioural model counts base ticks per channel and predicts all outputs
// one cycle ahead; directed scenarios additionally check absolute cycle
// positions derived by hand from the timing rules.
module tb_clkgen_tick_mc;

  localparam int CD  = 4;
  localparam int PSW = 3;
  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int VW  = 1 + 3 * NCH;

  logic              iCLK;
  logic              iRESET;
  logic              iCK_RUN;
  logic              iCK_RST;
  logic [NCH-1:0]    iCH_START;
  logic [NCH-1:0]    iCH_STOP;
  logic [NCH-1:0]    iCH_MODE;
  logic [NCH*PW-1:0] iCH_PERIOD;
  logic [NCH-1:0]    iCH_CLR;
  logic              oBASE_TICK;
  logic [NCH-1:0]    oCH_TICK;
  logic [NCH-1:0]    oCH_DONE;
  logic [NCH-1:0]    oCH_BUSY;

  clkgen_tick_mc #(.CLK_DIV(CD), .PSW(PSW), .NCH(NCH), .PW(PW)) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iCK_RUN    (iCK_RUN),
    .iCK_RST    (iCK_RST),
    .iCH_START  (iCH_START),
    .iCH_STOP   (iCH_STOP),
    .iCH_MODE   (iCH_MODE),
    .iCH_PERIOD (iCH_PERIOD),
    .iCH_CLR    (iCH_CLR),
    .oBASE_TICK (oBASE_TICK),
    .oCH_TICK   (oCH_TICK),
    .oCH_DONE   (oCH_DONE),
    .oCH_BUSY   (oCH_BUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: elapsed base ticks per channel against its period.
  // ---------------------------------------------------------------------------
  int m_phase;
  bit m_base;
  bit m_running [NCH];
  bit m_oneshot [NCH];
  int m_per     [NCH];
  int m_elapsed [NCH];
  bit m_tick    [NCH];
  bit m_done    [NCH];

  task automatic model_step();
    bit base_now;
    int p;
    base_now = m_base;
    if (iRESET) begin
      m_phase = 0;
      m_base  = 0;
      for (int c = 0; c < NCH; c++) begin
        m_running[c] = 0; m_oneshot[c] = 0; m_per[c] = 0;
        m_elapsed[c] = 0; m_tick[c] = 0; m_done[c] = 0;
      end
      return;
    end
    if (iCK_RST) begin
      m_phase = 0;
      m_base  = 0;
      for (int c = 0; c < NCH; c++) begin
        m_running[c] = 0; m_oneshot[c] = 0; m_per[c] = 0;
        m_elapsed[c] = 0; m_tick[c] = 0;
        m_done[c] = m_done[c] & !iCH_CLR[c];
      end
      return;
    end
    m_base = 0;
    if (iCK_RUN) begin
      m_phase = m_phase + 1;
      if (m_phase == CD) begin
        m_phase = 0;
        m_base  = 1;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      m_tick[c] = 0;
      p = int'(iCH_PERIOD[c*PW +: PW]);
      if (p == 0) p = 1;
      if (iCH_STOP[c]) begin
        m_running[c] = 0;
        m_elapsed[c] = 0;
      end else if (iCH_START[c]) begin
        m_running[c] = 1;
        m_oneshot[c] = iCH_MODE[c];
        m_per[c]     = p;
        m_elapsed[c] = 0;
      end else if (m_running[c] && base_now) begin
        m_elapsed[c] = m_elapsed[c] + 1;
        if (m_elapsed[c] == m_per[c]) begin
          m_tick[c]    = 1;
          m_elapsed[c] = 0;
          if (m_oneshot[c]) m_running[c] = 0;
          else              m_per[c] = p;
        end
      end
      m_done[c] = m_tick[c] | (m_done[c] & !iCH_CLR[c]);
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NCH-1:0] t, d, b;
    for (int c = 0; c < NCH; c++) begin
      t[c] = m_tick[c];
      d[c] = m_done[c];
      b[c] = m_running[c];
    end
    return {m_base, t, d, b};
  endfunction

  logic [VW-1:0] dut_vec;
  assign dut_vec = {oBASE_TICK, oCH_TICK, oCH_DONE, oCH_BUSY};

  // Advance the model with the inputs the DUT is about to sample, then step
  // one clock and settle just after the edge.
  task automatic cyc();
    model_step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_period(input int ch, input int val);
    iCH_PERIOD[ch*PW +: PW] = PW'(val);
  endtask

  // Put the prescaler at count 0 with all channels idle.
  task automatic phase_sync();
    iCK_RUN = 1'b0;
    iCK_RST = 1'b1;
    cyc();
    iCK_RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    iRESET = 1'b1; iCK_RUN = 1'b1; iCH_START = '1; iCH_CLR = '0;
    cyc();
    cyc();
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_values got %h want %h", dut_vec, {VW{1'b0}});
    end
    iRESET = 1'b0; iCK_RUN = 1'b0; iCH_START = '0;
    cyc();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got %h want %h", dut_vec, exp_vec());
    end
    $display("test_reset done");
  endtask

  task automatic test_prescaler();
    bit e;
    phase_sync();
    iCK_RUN = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      e = (k == 4) || (k == 8) || (k == 18);
      checks++;
      if (oBASE_TICK !== e) begin
        errors++;
        $display("FAIL base_timing cycle %0d got %b want %b", k, oBASE_TICK, e);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL model_prescaler cycle %0d got %h want %h", k, dut_vec, exp_vec());
      end
      if (oBASE_TICK === 1'b1) $display("base tick at cycle %0d", k);
      iCK_RUN = !(k >= 9 && k < 15);
    end
    iCK_RUN = 1'b0;
  endtask

  task automatic test_periodic();
    phase_sync();
    set_period(0, 3);
    iCH_MODE[0] = 1'b0; iCH_START[0] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      iCH_START = '0;
      checks++;
      if (oCH_TICK[0] !== ((k == 13) || (k == 25) || (k == 37))) begin
        errors++;
        $display("FAIL periodic_tick cycle %0d got %b", k, oCH_TICK[0]);
      end
      checks++;
      if (oCH_DONE[0] !== (k >= 13) || oCH_BUSY[0] !== 1'b1) begin
        errors++;
        $display("FAIL periodic_flags cycle %0d got done=%b busy=%b want done=%b busy=1",
                 k, oCH_DONE[0], oCH_BUSY[0], (k >= 13));
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL model_periodic cycle %0d got %h want %h", k, dut_vec, exp_vec());
      end
      if (oCH_TICK[0] === 1'b1) $display("periodic ch0 tick at cycle %0d", k);
    end
  endtask

  task automatic test_oneshot();
    phase_sync();
    set_period(1, 2);
    iCH_MODE[1] = 1'b1; iCH_START[1] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      iCH_START = '0;
      checks++;
      if (oCH_TICK[1] !== (k == 9) || oCH_BUSY[1] !== (k < 9) || oCH_DONE[1] !== (k >= 9)) begin
        errors++;
        $display("FAIL oneshot cycle %0d got tick=%b busy=%b done=%b want %b %b %b",
                 k, oCH_TICK[1], oCH_BUSY[1], oCH_DONE[1], (k == 9), (k < 9), (k >= 9));
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL model_oneshot cycle %0d got %h want %h", k, dut_vec, exp_vec());
      end
    end
    iCH_CLR[1] = 1'b1;
    cyc();
    iCH_CLR = '0;
    checks++;
    if (oCH_DONE[1] !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL clear_done got done=%b vec=%h want done=0 vec=%h", oCH_DONE[1], dut_vec, exp_vec());
    end
    $display("oneshot ch1 done cleared");
    // Clear lands on the same edge as a new expiry: the set must win.
    phase_sync();
    iCH_START[1] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      iCH_START = '0;
      iCH_CLR[1] = (k == 8);
      checks++;
      if (oCH_DONE[1] !== (k >= 9) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL clr_vs_set cycle %0d got done=%b vec=%h want done=%b vec=%h",
                 k, oCH_DONE[1], dut_vec, (k >= 9), exp_vec());
      end
    end
    iCH_CLR = '0;
  endtask

  task automatic test_period_change();
    phase_sync();
    set_period(2, 0);
    iCH_MODE[2] = 1'b0; iCH_START[2] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      iCH_START = '0;
      checks++;
      if (oCH_TICK[2] !== ((k == 5) || (k == 9) || (k == 13)) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL period_zero cycle %0d got tick=%b vec=%h want vec=%h", k, oCH_TICK[2], dut_vec, exp_vec());
      end
    end
    phase_sync();
    set_period(2, 5);
    iCH_START[2] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      iCH_START = '0;
      if (k == 10) set_period(2, 2);
      checks++;
      if (oCH_TICK[2] !== ((k == 21) || (k == 29) || (k == 37)) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL period_change cycle %0d got tick=%b vec=%h want vec=%h", k, oCH_TICK[2], dut_vec, exp_vec());
      end
      if (oCH_TICK[2] === 1'b1) $display("period change ch2 tick at cycle %0d", k);
    end
  endtask

  task automatic test_stop_start_expiry();
    phase_sync();
    set_period(3, 2);
    iCH_MODE[3] = 1'b0; iCH_START[3] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      iCH_START[3] = (k == 8);
      iCH_STOP[3]  = (k == 8);
      checks++;
      if (oCH_TICK[3] !== 1'b0 || oCH_BUSY[3] !== (k < 9) || oCH_DONE[3] !== 1'b0) begin
        errors++;
        $display("FAIL stop_wins cycle %0d got tick=%b busy=%b done=%b want 0 %b 0",
                 k, oCH_TICK[3], oCH_BUSY[3], oCH_DONE[3], (k < 9));
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL model_stop cycle %0d got %h want %h", k, dut_vec, exp_vec());
      end
    end
    iCH_STOP = '0; iCH_START = '0;
    $display("stop+start at expiry on ch3 handled");
  endtask

  task automatic test_ck_rst();
    phase_sync();
    set_period(0, 3); set_period(1, 1);
    iCH_MODE = '0; iCH_START = 4'b0011; iCK_RUN = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      iCH_START = '0;
      iCK_RST = (k == 3);
      if (k == 4) begin
        checks++;
        if (oBASE_TICK !== 1'b0 || oCH_BUSY !== 4'b0000 || oCH_DONE !== 4'b0111) begin
          errors++;
          $display("FAIL ck_rst got base=%b busy=%b done=%b want 0 0000 0111",
                   oBASE_TICK, oCH_BUSY, oCH_DONE);
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL model_ck_rst cycle %0d got %h want %h", k, dut_vec, exp_vec());
      end
    end
    iCK_RST = 1'b0;
    $display("soft clear mid-run handled");
  endtask

  task automatic test_sreset();
    phase_sync();
    set_period(0, 3);
    iCH_MODE = '0; iCH_START[0] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      iCH_START = '0;
      iRESET = (k == 12);
    end
    checks++;
    if (dut_vec !== '0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL sreset_mid_run got %h want %h", dut_vec, {VW{1'b0}});
    end
    iCH_START[0] = 1'b1; iCK_RUN = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      cyc();
      iCH_START = '0;
      checks++;
      if (oCH_TICK[0] !== ((k == 13) || (k == 25)) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL sreset_restart cycle %0d got tick=%b vec=%h want vec=%h", k, oCH_TICK[0], dut_vec, exp_vec());
      end
    end
    $display("sync reset mid-run and restart checked");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      iCK_RUN = ($urandom_range(0, 9) != 0);
      iCK_RST = ($urandom_range(0, 299) == 0);
      iRESET  = ($urandom_range(0, 999) == 0);
      for (int c = 0; c < NCH; c++) begin
        iCH_START[c] = ($urandom_range(0, 39) == 0);
        iCH_STOP[c]  = ($urandom_range(0, 79) == 0);
        iCH_CLR[c]   = ($urandom_range(0, 19) == 0);
        iCH_MODE[c]  = $urandom_range(0, 1);
        if ($urandom_range(0, 29) == 0) set_period(c, $urandom_range(0, 6));
        if (iCH_START[c])
          $display("rand cyc %0d ch%0d start mode=%0d period=%0d stop=%0d",
                   n, c, iCH_MODE[c], iCH_PERIOD[c*PW +: PW], iCH_STOP[c]);
      end
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL model_random cyc %0d got %h want %h", n, dut_vec, exp_vec());
      end
    end
    iCK_RUN = 1'b0; iCK_RST = 1'b0; iRESET = 1'b0;
    iCH_START = '0; iCH_STOP = '0; iCH_CLR = '0;
  endtask

  initial begin
    iRESET = 1'b1; iCK_RUN = 1'b0; iCK_RST = 1'b0;
    iCH_START = '0; iCH_STOP = '0; iCH_MODE = '0; iCH_CLR = '0;
    iCH_PERIOD = '0;
    test_reset();
    test_prescaler();
    test_periodic();
    test_oneshot();
    test_period_change();
    test_stop_start_expiry();
    test_ck_rst();
    test_sreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
